multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM: fetch, decode, execute, memory, writeback, halt
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_wrt,
    output logic        branch,
    output logic        jump,
    output logic        ir_wrt,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        reg_wrt,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic [2:0]  alu_op,
    output logic [2:0]  state,
    output logic        halted,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ADDU, C_SUBU, C_AND, C_OR, C_SLT,
        C_ADDIU, C_ORI, C_LW, C_SW, C_BEQ, C_J, C_HALT
    } cls_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    state_t cur, nxt;
    cls_t   cls, dec_cls;

    always_comb begin
        dec_cls = C_NOP;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100001: dec_cls = C_ADDU;
                    6'b100011: dec_cls = C_SUBU;
                    6'b100100: dec_cls = C_AND;
                    6'b100101: dec_cls = C_OR;
                    6'b101010: dec_cls = C_SLT;
                    default:   dec_cls = C_NOP;
                endcase
            end
            6'b001001: dec_cls = C_ADDIU;
            6'b001101: dec_cls = C_ORI;
            6'b100011: dec_cls = C_LW;
            6'b101011: dec_cls = C_SW;
            6'b000100: dec_cls = C_BEQ;
            6'b000010: dec_cls = C_J;
            6'b111111: dec_cls = C_HALT;
            default:   dec_cls = C_NOP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= S_IF;
            cls <= C_NOP;
        end else begin
            cur <= nxt;
            if (cur == S_ID)
                cls <= dec_cls;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            retired <= 32'd0;
        else if (pc_wrt)
            retired <= retired + 32'd1;
    end

    assign state  = cur;
    assign halted = (cur == S_HALT);

    // ID acts on the freshly decoded class; later states only see the registered one
    always_comb begin
        nxt        = S_IF;
        pc_wrt     = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        ir_wrt     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_wrt    = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_ADD;
        case (cur)
            S_IF: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_wrt = 1'b1;
                    nxt    = S_ID;
                end else begin
                    nxt = S_IF;
                end
            end
            S_ID: begin
                case (dec_cls)
                    C_J: begin
                        pc_wrt = 1'b1;
                        jump   = 1'b1;
                        nxt    = S_IF;
                    end
                    C_HALT: nxt = S_HALT;
                    C_NOP: begin
                        pc_wrt = 1'b1;
                        nxt    = S_IF;
                    end
                    default: nxt = S_EX;
                endcase
            end
            S_EX: begin
                case (cls)
                    C_ADDU:  begin alu_op = ALU_ADD; nxt = S_WB; end
                    C_SUBU:  begin alu_op = ALU_SUB; nxt = S_WB; end
                    C_AND:   begin alu_op = ALU_AND; nxt = S_WB; end
                    C_OR:    begin alu_op = ALU_OR;  nxt = S_WB; end
                    C_SLT:   begin alu_op = ALU_SLT; nxt = S_WB; end
                    C_ADDIU: begin alu_src = 1'b1; alu_op = ALU_ADD; nxt = S_WB; end
                    C_ORI:   begin alu_src = 1'b1; alu_op = ALU_OR;  nxt = S_WB; end
                    C_LW, C_SW: begin
                        alu_src = 1'b1;
                        alu_op  = ALU_ADD;
                        nxt     = S_MEM;
                    end
                    C_BEQ: begin
                        alu_op = ALU_SUB;
                        pc_wrt = 1'b1;
                        branch = zero;
                        nxt    = S_IF;
                    end
                    default: nxt = S_IF;
                endcase
            end
            S_MEM: begin
                mem_rd = (cls == C_LW);
                mem_wr = (cls == C_SW);
                if (mem_ready) begin
                    if (cls == C_SW) begin
                        pc_wrt = 1'b1;
                        nxt    = S_IF;
                    end else begin
                        nxt = S_WB;
                    end
                end else begin
                    nxt = S_MEM;
                end
            end
            S_WB: begin
                reg_wrt    = 1'b1;
                pc_wrt     = 1'b1;
                reg_dst    = (cls == C_ADDU) || (cls == C_SUBU) || (cls == C_AND) ||
                             (cls == C_OR)   || (cls == C_SLT);
                mem_to_reg = (cls == C_LW);
                nxt        = S_IF;
            end
            S_HALT: nxt = S_HALT;
            default: nxt = S_IF;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl with a phase-list reference model
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  op = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_wrt, branch, jump, ir_wrt, mem_rd, mem_wr;
    logic        reg_wrt, reg_dst, alu_src, mem_to_reg, halted;
    logic [2:0]  alu_op, state;
    logic [31:0] retired;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_wrt(pc_wrt), .branch(branch), .jump(jump),
        .ir_wrt(ir_wrt), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wrt(reg_wrt),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .alu_op(alu_op), .state(state), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        pc_wrt, branch, jump, ir_wrt, mem_rd, mem_wr;
        logic        reg_wrt, reg_dst, alu_src, mem_to_reg;
        logic [2:0]  alu_op;
        logic        halted;
        logic [31:0] retired;
    } obs_t;

    localparam int K_ADDU = 0, K_SUBU = 1, K_AND = 2, K_OR = 3, K_SLT = 4;
    localparam int K_ADDIU = 5, K_ORI = 6, K_LW = 7, K_SW = 8, K_BEQ = 9;
    localparam int K_J = 10, K_NOPOP = 11, K_NOPF = 12, K_HALT = 13;

    obs_t        exp_q[$];
    obs_t        act, mon_e;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_retired = 32'd0;

    assign act = {state, pc_wrt, branch, jump, ir_wrt, mem_rd, mem_wr, reg_wrt,
                  reg_dst, alu_src, mem_to_reg, alu_op, halted, retired};

    task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("cycle_outputs", 64'(act), 64'(mon_e));
        end
    end

    // One clock cycle: drive inputs, record what the spec requires for it, advance.
    task automatic push_step(input obs_t e, input bit rdy, input bit id_cycle,
                             input logic [5:0] o, input logic [5:0] f,
                             input bit z, input bit force_sw);
        mem_ready = rdy;
        zero      = z;
        if (id_cycle) begin
            op = o; funct = f;
        end else if (force_sw) begin
            op = 6'b101011; funct = 6'($urandom);
        end else begin
            op = 6'($urandom); funct = 6'($urandom);
        end
        e.retired = model_retired;
        if (e.pc_wrt) model_retired = model_retired + 32'd1;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    function automatic logic [2:0] kind_alu(input int k);
        case (k)
            K_SUBU, K_BEQ: return 3'b001;
            K_AND:         return 3'b010;
            K_OR, K_ORI:   return 3'b011;
            K_SLT:         return 3'b100;
            default:       return 3'b000;
        endcase
    endfunction

    task automatic run_instr(input int k, input int z_ex, input int if_stall,
                             input int mem_stall, input bit force_sw, input bit abort_mem);
        logic [5:0] o, f;
        obs_t e;
        bit   z, is_mem, last;
        f = 6'($urandom);
        case (k)
            K_ADDU:  begin o = 6'b000000; f = 6'b100001; end
            K_SUBU:  begin o = 6'b000000; f = 6'b100011; end
            K_AND:   begin o = 6'b000000; f = 6'b100100; end
            K_OR:    begin o = 6'b000000; f = 6'b100101; end
            K_SLT:   begin o = 6'b000000; f = 6'b101010; end
            K_ADDIU: o = 6'b001001;
            K_ORI:   o = 6'b001101;
            K_LW:    o = 6'b100011;
            K_SW:    o = 6'b101011;
            K_BEQ:   o = 6'b000100;
            K_J:     o = 6'b000010;
            K_HALT:  o = 6'b111111;
            K_NOPOP: begin
                case ($urandom_range(0, 3))
                    0: o = 6'b000001;
                    1: o = 6'b001000;
                    2: o = 6'b110000;
                    default: o = 6'b011111;
                endcase
            end
            default: begin
                o = 6'b000000;
                case ($urandom_range(0, 3))
                    0: f = 6'b100000;
                    1: f = 6'b000000;
                    2: f = 6'b100010;
                    default: f = 6'b111111;
                endcase
            end
        endcase
        z = (z_ex < 0) ? 1'($urandom) : 1'(z_ex);

        for (int i = 0; i <= if_stall; i++) begin
            e = '0; e.st = 3'd0; e.mem_rd = 1'b1; e.ir_wrt = (i == if_stall);
            push_step(e, i == if_stall, 1'b0, o, f, 1'($urandom), force_sw);
        end

        e = '0; e.st = 3'd1;
        if (k == K_J) begin e.pc_wrt = 1'b1; e.jump = 1'b1; end
        if (k == K_NOPOP || k == K_NOPF) e.pc_wrt = 1'b1;
        push_step(e, 1'($urandom), 1'b1, o, f, 1'($urandom), force_sw);
        if (k == K_J || k == K_NOPOP || k == K_NOPF || k == K_HALT) return;

        is_mem = (k == K_LW || k == K_SW);
        e = '0; e.st = 3'd2; e.alu_op = kind_alu(k);
        e.alu_src = (k == K_ADDIU || k == K_ORI || is_mem);
        if (k == K_BEQ) begin e.pc_wrt = 1'b1; e.branch = z; end
        push_step(e, 1'($urandom), 1'b0, o, f, z, force_sw);
        if (k == K_BEQ) return;

        if (is_mem) begin
            for (int i = 0; i <= mem_stall; i++) begin
                last = (i == mem_stall) && !abort_mem;
                e = '0; e.st = 3'd3; e.mem_rd = (k == K_LW); e.mem_wr = (k == K_SW);
                e.pc_wrt = (k == K_SW) && last;
                if (abort_mem) begin
                    mem_ready = 1'b0;
                    e.retired = model_retired;
                    exp_q.push_back(e);
                    @(negedge clk); #2;
                    reset = 1'b1;
                    #1;
                    check("rst_mid_mem_wr", 64'(mem_wr), 64'd0);
                    check("rst_mid_pc_wrt", 64'(pc_wrt), 64'd0);
                    check("rst_mid_reg_wrt", 64'(reg_wrt), 64'd0);
                    check("rst_mid_state", 64'(state), 64'd0);
                    check("rst_mid_retired", 64'(retired), 64'd0);
                    @(posedge clk); #1;
                    check("rst_hold_state", 64'(state), 64'd0);
                    reset = 1'b0;
                    model_retired = 32'd0;
                    return;
                end
                push_step(e, last, 1'b0, o, f, 1'($urandom), force_sw);
            end
            if (k == K_SW) return;
        end

        e = '0; e.st = 3'd4; e.reg_wrt = 1'b1; e.pc_wrt = 1'b1;
        e.reg_dst = (k <= K_SLT); e.mem_to_reg = (k == K_LW);
        push_step(e, 1'($urandom), 1'b0, o, f, 1'($urandom), force_sw);
    endtask

    task automatic halt_idle(input int n);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            e = '0; e.st = 3'd5; e.halted = 1'b1;
            push_step(e, 1'($urandom), 1'b0, 6'd0, 6'd0, 1'($urandom), 1'b0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_state", 64'(state), 64'd0);
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_pc_wrt", 64'(pc_wrt), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_retired = 32'd0;
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        run_instr(K_ADDU, -1, 0, 0, 1'b0, 1'b0);
        check("addu_retired", 64'(retired), 64'd1);
        run_instr(K_LW, -1, 0, 2, 1'b0, 1'b0);
        run_instr(K_BEQ, 1, 0, 0, 1'b0, 1'b0);
        run_instr(K_BEQ, 0, 0, 0, 1'b0, 1'b0);
        run_instr(K_ORI, -1, 0, 0, 1'b1, 1'b0);

        do_reset();
        run_instr(K_J, -1, 0, 0, 1'b0, 1'b0);
        run_instr(K_HALT, -1, 0, 0, 1'b0, 1'b0);
        halt_idle(10);
        check("halt_retired", 64'(retired), 64'd1);
        check("halt_flag", 64'(halted), 64'd1);
        do_reset();

        run_instr(K_SW, -1, 1, 3, 1'b0, 1'b1);

        for (int n = 0; n < 80; n++) begin
            int k;
            k = int'($urandom_range(0, 13));
            run_instr(k, -1, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      1'b0, 1'b0);
            if (k == K_HALT) begin
                halt_idle(3);
                do_reset();
            end
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
